// File: rtl/dma_reg_pkg.sv
// Purpose: shared register offsets, CTRL/STATUS bit positions and transfer FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_reg_pkg;

  // Word offsets (byte address bits [5:2]) inside the 64-byte register window
  localparam logic [3:0] OFF_CTRL      = 4'h0;
  localparam logic [3:0] OFF_SRC       = 4'h1;
  localparam logic [3:0] OFF_DST       = 4'h2;
  localparam logic [3:0] OFF_LEN       = 4'h3;
  localparam logic [3:0] OFF_STATUS    = 4'h4;
  localparam logic [3:0] OFF_XFER_CNT  = 4'h5;
  localparam logic [3:0] OFF_CUR_ADDR  = 4'h6;
  localparam logic [3:0] OFF_CYCLE_CNT = 4'h7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } xfer_state_e;

endpackage

// File: rtl/dma_xfer_engine.sv
// Purpose: descriptor-less transfer sequencer; counts words at BEAT_CYCLES per word (CYCLE_CNT when DMA_PERF_CNT_EN).
// Latency: start accepted at the edge it is sampled; one-cycle DONE state precedes return to IDLE.
// Backpressure: none; start is ignored unless IDLE, abort only acts in RUN.
module dma_xfer_engine
  import dma_reg_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int BEAT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done_set,
  output logic             abort_hit,
  output logic [LEN_W-1:0] xfer_cnt
`ifdef DMA_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_cnt
`endif
);

  localparam logic [3:0] BEAT_RELOAD = 4'(BEAT_CYCLES - 1);

  xfer_state_e      state_q, state_d;
  logic [3:0]       beat_q, beat_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             busy_q, busy_d;
`ifdef DMA_PERF_CNT_EN
  logic [31:0]      cyc_q, cyc_d;
`endif

  assign cnt_inc = cnt_q + LEN_W'(1);

  // Next-state: IDLE -> RUN (or straight to DONE on zero length) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
`ifdef DMA_PERF_CNT_EN
    cyc_d   = cyc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          beat_d  = BEAT_RELOAD;
          state_d = (len == '0) ? DONE : RUN;
`ifdef DMA_PERF_CNT_EN
          cyc_d   = 32'd0;
`endif
        end
      end
      RUN: begin
`ifdef DMA_PERF_CNT_EN
        cyc_d = cyc_q + 32'd1;
`endif
        if (abort) begin
          // Count is frozen where the abort landed
          state_d = IDLE;
        end else if (beat_q == 4'd0) begin
          cnt_d  = cnt_inc;
          beat_d = BEAT_RELOAD;
          if (cnt_inc == len) state_d = DONE;
        end else begin
          beat_d = beat_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and the registered busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= 4'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef DMA_PERF_CNT_EN
      cyc_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`ifdef DMA_PERF_CNT_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done_set  = (state_q == DONE);
  assign abort_hit = (state_q == RUN) && abort;
  assign xfer_cnt  = cnt_q;
`ifdef DMA_PERF_CNT_EN
  assign cycle_cnt = cyc_q;
`endif

endmodule

// File: rtl/dma_reg_responder.sv
// Purpose: DMA register-bus target: decode, CTRL/SRC/DST/LEN/STATUS bank, irq; 0x1C CYCLE_CNT when DMA_PERF_CNT_EN.
// Latency: reads return registered rdata one cycle after the request; writes take effect at the sampling edge.
// Backpressure: none; every request is accepted, out-of-window requests are ignored.
module dma_reg_responder
  import dma_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LEN_W       = 16,
  parameter int          BEAT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        valid,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        busy
);

  logic             in_win, wr_acc, rd_acc, mapped;
  logic [3:0]       off;
  logic             start_req, start_go, abort_req, err_evt;
  logic             eng_busy, done_set, abort_hit;
  logic [LEN_W-1:0] xfer_cnt;
  logic [31:0]      cur_addr, rd_val;
  logic             unused_addr_bits;
`ifdef DMA_PERF_CNT_EN
  logic [31:0]      cycle_cnt;
`endif

  logic             irq_en_q, irq_en_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d, err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  // Byte-lane bits carry no meaning on a word-only bus
  assign unused_addr_bits = ^addr[1:0];

  assign in_win = valid && (addr[31:6] == BASE_ADDR[31:6]);
  assign off    = addr[5:2];
  assign wr_acc = in_win && wr_en;
  assign rd_acc = in_win && !wr_en;
`ifdef DMA_PERF_CNT_EN
  assign mapped = (off <= OFF_CYCLE_CNT);
`else
  assign mapped = (off <= OFF_CUR_ADDR);
`endif

  assign start_req = wr_acc && (off == OFF_CTRL) && wdata[CTRL_START];
  assign abort_req = wr_acc && (off == OFF_CTRL) && wdata[CTRL_ABORT];
  assign start_go  = start_req && !eng_busy;
  assign cur_addr  = src_q + (32'(xfer_cnt) << 2);

  // Error sources: unmapped access, start or config write while busy, abort of a running transfer
  assign err_evt = (in_win && !mapped)
                || (start_req && eng_busy)
                || (wr_acc && eng_busy && ((off == OFF_SRC) || (off == OFF_DST) || (off == OFF_LEN)))
                || abort_hit;

  dma_xfer_engine #(
    .LEN_W       (LEN_W),
    .BEAT_CYCLES (BEAT_CYCLES)
  ) u_engine (
    .clk       (clk),
    .reset     (reset),
    .start     (start_go),
    .abort     (abort_req),
    .len       (len_q),
    .busy      (eng_busy),
    .done_set  (done_set),
    .abort_hit (abort_hit),
    .xfer_cnt  (xfer_cnt)
`ifdef DMA_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  // Read mux over pre-edge register contents; pulse bits of CTRL read as 0
  always_comb begin
    rd_val = UNMAPPED_RDATA;
    case (off)
      OFF_CTRL:      rd_val[CTRL_IRQ_EN] = irq_en_q;
      OFF_SRC:       rd_val = src_q;
      OFF_DST:       rd_val = dst_q;
      OFF_LEN:       rd_val = 32'(len_q);
      OFF_STATUS:    rd_val = {29'd0, err_q, done_q, eng_busy};
      OFF_XFER_CNT:  rd_val = 32'(xfer_cnt);
      OFF_CUR_ADDR:  rd_val = cur_addr;
`ifdef DMA_PERF_CNT_EN
      OFF_CYCLE_CNT: rd_val = cycle_cnt;
`endif
      default:       rd_val = UNMAPPED_RDATA;
    endcase
  end

  // Register bank update; engine set events override W1C clears
  always_comb begin
    irq_en_d = irq_en_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    done_d   = done_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    irq_d    = done_q && irq_en_q;
    if (wr_acc) begin
      case (off)
        OFF_CTRL: irq_en_d = wdata[CTRL_IRQ_EN];
        OFF_SRC:  if (!eng_busy) src_d = {wdata[31:2], 2'b00};
        OFF_DST:  if (!eng_busy) dst_d = {wdata[31:2], 2'b00};
        OFF_LEN:  if (!eng_busy) len_d = wdata[LEN_W-1:0];
        OFF_STATUS: begin
          if (wdata[STAT_DONE]) done_d = 1'b0;
          if (wdata[STAT_ERR])  err_d  = 1'b0;
        end
        default: ;
      endcase
    end
    if (rd_acc)   rdata_d = rd_val;
    if (start_go) done_d  = 1'b0;
    if (done_set) done_d  = 1'b1;
    if (err_evt)  err_d   = 1'b1;
  end

  // Register bank and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      len_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;
  assign busy  = eng_busy;

endmodule

// File: tb/tb_dma_reg_responder.sv
// Purpose: directed bench for dma_reg_responder; two instances on one bus (base 0x000 beat 1, base 0x100 beat 3).
// Latency: reads are checked one cycle after the request edge.
// Backpressure: none exercised; the bus has none.
module tb_dma_reg_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic        wr_en, valid;
  logic [31:0] rdata0, rdata1;
  logic        irq0, irq1, busy0, busy1;

  int n_chk = 0;
  int n_bad = 0;
  int bc;
  logic [31:0] v;

  always #5 clk = ~clk;

  dma_reg_responder #(.BASE_ADDR(32'h0000_0000), .LEN_W(16), .BEAT_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .valid(valid),
    .wdata(wdata), .rdata(rdata0), .irq(irq0), .busy(busy0)
  );

  dma_reg_responder #(.BASE_ADDR(32'h0000_0100), .LEN_W(16), .BEAT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .valid(valid),
    .wdata(wdata), .rdata(rdata1), .irq(irq1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
    addr = a; wr_en = 1'b0; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    r = a[8] ? rdata1 : rdata0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus_rd(a, r);
    check(tag, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; valid = 1'b0; wr_en = 1'b0; addr = 32'd0; wdata = 32'd0;
    cyc(2);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_irq0",   irq0,   1'b0);
    check("rst_busy0",  busy0,  1'b0);
    check("rst_busy1",  busy1,  1'b0);
    reset = 1'b1;
    cyc(1);

    // Reset in the middle of a long transfer
    bus_wr(32'h0C, 32'd100);
    bus_wr(32'h00, 32'h1);
    cyc(20);
    check("midrun_busy", busy0, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("midrst_busy",  busy0,  1'b0);
    check("midrst_irq",   irq0,   1'b0);
    check("midrst_rdata", rdata0, 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    rd_chk("midrst_status", 32'h10, 32'h0);
    rd_chk("midrst_xfer",   32'h14, 32'h0);
    rd_chk("midrst_len",    32'h0C, 32'h0);

    // SRC alignment, rdata hold, window and unmapped handling
    bus_wr(32'h04, 32'h1000_0003);
    rd_chk("src_align", 32'h04, 32'h1000_0000);
    cyc(3);
    check("rdata_hold", rdata0, 32'h1000_0000);
    bus_rd(32'h40, v);
    check("oow_hold", v, 32'h1000_0000);
    rd_chk("oow_noerr",   32'h10, 32'h0);
    rd_chk("unmapped_rd", 32'h24, 32'h0);
    rd_chk("err_set_rd",  32'h10, 32'h4);
    bus_wr(32'h10, 32'h4);
    rd_chk("err_w1c",     32'h10, 32'h0);
    bus_wr(32'h28, 32'hFF);
    rd_chk("err_set_wr",  32'h10, 32'h4);
    bus_wr(32'h10, 32'h4);

    // LEN=4 transfer with interrupt enabled
    bus_wr(32'h0C, 32'd4);
    bus_wr(32'h00, 32'h3);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy0) break;
      bc++;
      cyc(1);
    end
    check("len4_busy_cycles", bc, 32'd5);
    check("len4_irq_lag", irq0, 1'b0);
    cyc(1);
    check("len4_irq_rise", irq0, 1'b1);
    rd_chk("len4_xfer",   32'h14, 32'd4);
    rd_chk("len4_cur",    32'h18, 32'h1000_0010);
    rd_chk("len4_status", 32'h10, 32'h2);
    rd_chk("len4_ctrl",   32'h00, 32'h2);
    bus_wr(32'h10, 32'h2);
    check("w1c_irq_hold", irq0, 1'b1);
    cyc(1);
    check("w1c_irq_drop", irq0, 1'b0);

    // Zero-length transfer goes straight through DONE
    bus_wr(32'h0C, 32'd0);
    bus_wr(32'h00, 32'h1);
    check("len0_busy", busy0, 1'b1);
    cyc(1);
    check("len0_idle", busy0, 1'b0);
    rd_chk("len0_status", 32'h10, 32'h2);
    rd_chk("len0_xfer",   32'h14, 32'd0);
    check("len0_noirq", irq0, 1'b0);

    // Abort after three words; start and LEN writes while busy
    bus_wr(32'h10, 32'h2);
    bus_wr(32'h0C, 32'd10);
    bus_wr(32'h00, 32'h3);
    bus_wr(32'h00, 32'h3);
    bus_wr(32'h0C, 32'd7);
    cyc(1);
    bus_wr(32'h00, 32'h6);
    check("abort_idle", busy0, 1'b0);
    rd_chk("abort_xfer",   32'h14, 32'd3);
    rd_chk("abort_status", 32'h10, 32'h4);
    rd_chk("abort_len",    32'h0C, 32'd10);
    rd_chk("abort_cur",    32'h18, 32'h1000_000C);
    check("abort_noirq", irq0, 1'b0);

    // Second instance: three cycles per word
    bus_wr(32'h10C, 32'd5);
    bus_wr(32'h100, 32'h1);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy1) break;
      bc++;
      cyc(1);
    end
    check("beat3_busy_cycles", bc, 32'd16);
    check("beat3_dut0_quiet", busy0, 1'b0);
    rd_chk("beat3_xfer", 32'h114, 32'd5);
`ifdef DMA_PERF_CNT_EN
    rd_chk("perf_cycle_cnt", 32'h11C, 32'd15);
    rd_chk("perf_status",    32'h110, 32'h2);
`else
    rd_chk("noperf_rd",      32'h11C, 32'd0);
    rd_chk("noperf_status",  32'h110, 32'h6);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
